reg4_load_ctrl: RTL
===================

Name: reg4_load_ctrl

Overview:
Controller that sequences loading of a 4-bit flip-flop register bank from a single data switch and a push key. It debounces the key and synchronizes both board inputs. It then either broadcasts the data bit into all four bits, or fills the bits one per key press, with a fill timeout. It owns the register and drives per-bit write-enable strobes and LED status outputs.

Parameters:
DEB_CYCLES, 4, consecutive cycles the synchronized key must differ from the debounced level before that level flips (min 1).
TIMEOUT, 1000, idle cycles allowed in FILL before the fill aborts (min 2).

Ports:
clk  input  1  single system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
key_raw  input  1  push key, asynchronous, active-high, bouncy
d_raw  input  1  data switch, asynchronous
mode  input  1  0 = broadcast load, 1 = sequential fill; sampled only when a press is accepted in IDLE
q  output  4  register contents
we  output  4  write-enable strobe, one cycle, coincident with the q update
idx  output  2  next bit position to fill (LED)
busy  output  1  high while in FILL
done  output  1  one-cycle pulse when a load completes
err  output  1  sticky timeout flag
key_led  output  1  debounced key level

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: q=0, we=0, idx=0, busy=0, done=0, err=0, key_led=0. State=IDLE. Sync flops, counters and debounced level are all cleared.
- Sync: key_raw and d_raw each pass through 2 flops (s1, s2). Only the s2 copies are used.
- Debounce:
  - When key_s2 != deb, cnt increments.
  - When key_s2 == deb, cnt clears.
  - When cnt == DEB_CYCLES-1 and key_s2 != deb, deb flips and cnt clears.
  - Any glitch shorter than DEB_CYCLES is rejected. The release edge is debounced identically.
  - press = deb & ~deb_d, where deb_d is deb delayed one cycle.
- Latency: key_raw is first sampled high at edge E0. deb rises at E(DEB_CYCLES+1). The FSM acts, q updates and we asserts at E(DEB_CYCLES+2).
  - The d value written is d_s2 in the press cycle.
- FSM states: IDLE, FILL, DONE.
  - IDLE, press, mode=0: q <= {4{d}}, we=1111, done pulses at the same edge. Stay in IDLE. err clears.
  - IDLE, press, mode=1: q[0] <= d, we=0001, idx <= 1. Go to FILL, busy=1. err clears.
  - FILL, press: q[idx] <= d, we = one-hot(idx), idx increments.
    - If the written idx was 3: go to DONE, idx <= 0.
    - The timeout counter clears on every press.
  - FILL, no press: tcnt increments. When tcnt reaches TIMEOUT-1, go to IDLE. err <= 1, idx <= 0, busy <= 0. Already-written q bits are retained.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE. A press arriving in DONE is dropped (at least DEB_CYCLES separate presses, so this is unreachable in practice).
- Other rules:
  - Only one press is accepted per debounced rising edge; holding the key does not repeat.
  - Changes to mode during FILL are ignored.
  - rst asserted mid-FILL returns everything to reset values at that edge, including q.
  - we is all zeros except in write cycles. done and we are registered outputs.

Optional Feature:
REG4_SHIFT_EN
- Defined: in mode=1, each press shifts instead of addressing: q <= {q[2:0], d}, we=1111. The idx counter, the 4-press completion to DONE and the timeout are unchanged.
- Undefined: addressed one-hot fill as described above. Broadcast mode is identical in both builds.

Test Plan:
Overrides for all scenarios: DEB_CYCLES=4, TIMEOUT=20.
1. Reset, then key_raw=1 held, d_raw=1, mode=0 -> at E6 after the first high sample, q=1111, we=1111 for one cycle, done=1 for one cycle, busy=0.
2. mode=1, four clean presses with d=1,0,1,1 -> we=0001,0010,0100,1000; final q=1101; done pulses after the 4th; idx returns to 0.
3. key_raw bounce 1,0,1,0 each lasting 3 cycles, then steady 1 for 10 cycles -> exactly one write; key_led rises once.
4. mode=1, two presses (d=1,1), then 20 idle cycles -> q=0011, err=1, busy=0. Next press in IDLE, mode=0, d=0 -> q=0000, err=0.
5. rst asserted for one cycle while in FILL after 2 writes -> at the next edge q=0, idx=0, busy=0, err=0, state IDLE.
6. With REG4_SHIFT_EN defined, mode=1, presses d=1,0,0,1 -> q sequence 0001,0010,0100,1001; we=1111 on each write; done after the 4th press.

Source files
------------

// File: rtl/reg4_load_ctrl.sv
// -----------------------------------------------------------------------------
// reg4_load_ctrl
//
// Purpose:
//   Sequences loading of a 4-bit register bank from a single data switch and a
//   push key. Both board inputs are synchronized through two flops. The key is
//   debounced, and each debounced rising edge is one accepted press. A press in
//   IDLE either broadcasts the data bit into all four bits (mode=0), or starts a
//   sequential fill that writes one bit per press (mode=1). A fill that sees no
//   press for TIMEOUT cycles is aborted and flags a sticky error.
//
// Build option:
//   REG4_SHIFT_EN - when defined, sequential fill shifts the data bit in from
//                   the LSB (q <= {q[2:0], d}, we=1111) instead of writing the
//                   addressed bit. Completion, idx and timeout are unchanged.
//
// Parameters:
//   DEB_CYCLES - consecutive differing samples needed to flip the debounced key
//   TIMEOUT    - idle cycles tolerated in FILL before the fill aborts
//
// Ports:
//   clk      in   system clock, all logic on posedge
//   rst      in   synchronous active-high reset
//   key_raw  in   asynchronous bouncy push key (active high)
//   d_raw    in   asynchronous data switch
//   mode     in   0 = broadcast, 1 = sequential fill (sampled on accepted press)
//   q        out  register contents
//   we       out  per-bit write strobe, coincident with the q update
//   idx      out  next bit position to fill
//   busy     out  high while filling
//   done     out  one-cycle pulse when a load completes
//   err      out  sticky fill-timeout flag
//   key_led  out  debounced key level
// -----------------------------------------------------------------------------
module reg4_load_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_raw,
    input  logic       d_raw,
    input  logic       mode,
    output logic [3:0] q,
    output logic [3:0] we,
    output logic [1:0] idx,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       key_led
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic          r_key_s1;
    logic          r_key_s2;
    logic          r_d_s1;
    logic          r_d_s2;
    logic [DW-1:0] r_deb_cnt;
    logic          r_deb;
    logic          r_deb_d;
    logic [TW-1:0] r_tcnt;
    state_t        r_state;
    logic [3:0]    r_q;
    logic [3:0]    r_we;
    logic [1:0]    r_idx;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          w_press;

    // One accepted press per debounced rising edge; holding does not repeat.
    assign w_press = r_deb & ~r_deb_d;

    assign q       = r_q;
    assign we      = r_we;
    assign idx     = r_idx;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign key_led = r_deb;

    // Two-flop synchronizers for the asynchronous key and data inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_s1 <= 1'b0;
            r_key_s2 <= 1'b0;
            r_d_s1   <= 1'b0;
            r_d_s2   <= 1'b0;
        end else begin
            r_key_s1 <= key_raw;
            r_key_s2 <= r_key_s1;
            r_d_s1   <= d_raw;
            r_d_s2   <= r_d_s1;
        end
    end

    // Debouncer: the level flips only after DEB_CYCLES consecutive differing
    // samples; any matching sample restarts the count. Both edges alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_cnt <= {DW{1'b0}};
            r_deb     <= 1'b0;
            r_deb_d   <= 1'b0;
        end else begin
            r_deb_d <= r_deb;
            if (r_key_s2 != r_deb) begin
                if (r_deb_cnt == DEB_MAX) begin
                    r_deb     <= r_key_s2;
                    r_deb_cnt <= {DW{1'b0}};
                end else begin
                    r_deb_cnt <= r_deb_cnt + DW'(1);
                end
            end else begin
                r_deb_cnt <= {DW{1'b0}};
            end
        end
    end

    // Load sequencer with registered register bank, strobes and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_q     <= 4'b0000;
            r_we    <= 4'b0000;
            r_idx   <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_tcnt  <= {TW{1'b0}};
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_we   <= 4'b0000;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        r_err <= 1'b0;
                        if (mode == 1'b0) begin
                            r_q    <= {4{r_d_s2}};
                            r_we   <= 4'b1111;
                            r_done <= 1'b1;
                        end else begin
`ifdef REG4_SHIFT_EN
                            r_q  <= {r_q[2:0], r_d_s2};
                            r_we <= 4'b1111;
`else
                            r_q[0] <= r_d_s2;
                            r_we   <= 4'b0001;
`endif
                            r_idx   <= 2'd1;
                            r_tcnt  <= {TW{1'b0}};
                            r_busy  <= 1'b1;
                            r_state <= S_FILL;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FILL: begin
                    if (w_press) begin
`ifdef REG4_SHIFT_EN
                        r_q  <= {r_q[2:0], r_d_s2};
                        r_we <= 4'b1111;
`else
                        r_q[r_idx] <= r_d_s2;
                        r_we       <= 4'b0001 << r_idx;
`endif
                        r_tcnt <= {TW{1'b0}};
                        if (r_idx == 2'd3) begin
                            // Last bit written: done is high for the single
                            // cycle the sequencer spends in DONE.
                            r_idx   <= 2'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end else if (r_tcnt == TMO_MAX) begin
                        // Abort: keep the bits already written.
                        r_err   <= 1'b1;
                        r_idx   <= 2'd0;
                        r_busy  <= 1'b0;
                        r_tcnt  <= {TW{1'b0}};
                        r_state <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_DONE: begin
                    // Any press landing here is intentionally dropped.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= 2'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
